// File: rtl/ram_reg_mover_if.sv
// Control bundle between a transfer requester (master) and ram_reg_mover (slave).
// The xfer_cnt statistic exists only when MOVER_STAT_EN is defined.
interface ram_reg_mover_if;
    logic        start;
    logic        dir;
    logic [15:0] ram_base;
    logic [4:0]  reg_base;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [1:0]  choice;
    logic        ram_wen;
    logic [15:0] ram_addr;
    logic        we;
    logic [4:0]  waddr;
    logic [4:0]  raddr1;
`ifdef MOVER_STAT_EN
    logic [15:0] xfer_cnt;
`endif

    modport master (
        output start, dir, ram_base, reg_base, count,
        input  busy, done, choice, ram_wen, ram_addr, we, waddr, raddr1
`ifdef MOVER_STAT_EN
        , input xfer_cnt
`endif
    );

    modport slave (
        input  start, dir, ram_base, reg_base, count,
        output busy, done, choice, ram_wen, ram_addr, we, waddr, raddr1
`ifdef MOVER_STAT_EN
        , output xfer_cnt
`endif
    );
endinterface

// File: rtl/ram_reg_mover.sv
// Block mover between RAM and register file: one start pulse moves 1-32 words.
// Optional completed-word statistic counter is built when MOVER_STAT_EN is defined.
module ram_reg_mover #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic           clk,
    input  logic           resetn,
    ram_reg_mover_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int unsigned PIPE_D     = (RD_LAT > 0) ? RD_LAT : 1;
    localparam int unsigned LAST       = PIPE_D - 1;
    localparam logic [1:0]  CH_EXT     = 2'b11;
    localparam logic [1:0]  CH_RAM2REG = 2'b01;
    localparam logic [1:0]  CH_REG2RAM = 2'b00;

    state_t      state_q;
    logic        dir_q;
    logic [15:0] ram_base_q;
    logic [4:0]  reg_base_q;
    logic [5:0]  cnt_q;
    logic [5:0]  k_q;
    logic [1:0]  drain_q;

    logic [1:0]  choice_q;
    logic        ram_wen_q;
    logic [15:0] ram_addr_q;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [4:0]  raddr1_q;
    logic        busy_q;
    logic        done_q;

    logic [PIPE_D-1:0] pipe_v_q;
    logic [4:0]        pipe_idx_q [PIPE_D];

    logic [5:0]  count_clamped;
    logic        issue_v;
    logic        issue_dir;
    logic [15:0] issue_ram;
    logic [4:0]  issue_reg;
    logic        push_v;
    logic        wb_v;
    logic [4:0]  wb_idx;

    // The issue for the next cycle: word 0 comes straight from the start inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_clamped = (bus.count > 6'd32) ? 6'd32 : bus.count;
        issue_v       = 1'b0;
        issue_dir     = dir_q;
        issue_ram     = ram_base_q + {10'd0, k_q};
        issue_reg     = reg_base_q + k_q[4:0];
        if (state_q == S_IDLE) begin
            issue_v   = bus.start && (count_clamped != 6'd0);
            issue_dir = bus.dir;
            issue_ram = bus.ram_base;
            issue_reg = bus.reg_base;
        end else if (state_q == S_RUN) begin
            issue_v = (k_q < cnt_q);
        end
        push_v = issue_v && !issue_dir;
    end

    if (RD_LAT == 0) begin : g_no_pipe
        assign wb_v   = push_v;
        assign wb_idx = issue_reg;
    end else begin : g_pipe
        assign wb_v   = pipe_v_q[LAST];
        assign wb_idx = pipe_idx_q[LAST];
    end

    // Register index travels alongside the RAM read so the write lands RD_LAT cycles later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_v_q <= '0;
            for (int i = 0; i < int'(PIPE_D); i++) pipe_idx_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift on the old values of its neighbour.
            pipe_v_q[0]   <= push_v;
            pipe_idx_q[0] <= issue_reg;
            for (int i = 1; i < int'(PIPE_D); i++) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            ram_base_q <= '0;
            reg_base_q <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            choice_q   <= CH_EXT;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            raddr1_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ram_wen_q <= issue_v && issue_dir;
            we_q      <= wb_v;
            done_q    <= 1'b0;
            if (wb_v) waddr_q <= wb_idx;
            if (issue_v) begin
                ram_addr_q <= issue_ram;
                if (issue_dir) raddr1_q <= issue_reg;
            end

            unique case (state_q)
                S_IDLE: if (bus.start) begin
                    dir_q      <= bus.dir;
                    ram_base_q <= bus.ram_base;
                    reg_base_q <= bus.reg_base;
                    cnt_q      <= count_clamped;
                    k_q        <= 6'd1;
                    busy_q     <= 1'b1;
                    if (count_clamped == 6'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_RUN;
                        choice_q <= bus.dir ? CH_REG2RAM : CH_RAM2REG;
                    end
                end
                S_RUN: begin
                    if (issue_v) begin
                        k_q <= k_q + 6'd1;
                    end else if (!dir_q && RD_LAT != 0) begin
                        state_q <= S_DRAIN;
                        drain_q <= 2'(RD_LAT - 1);
                    end else begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        choice_q <= CH_EXT;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        choice_q <= CH_EXT;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOVER_STAT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xfer_cnt_q <= '0;
        end else if ((we_q || ram_wen_q) && xfer_cnt_q != 16'hFFFF) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign bus.xfer_cnt = xfer_cnt_q;
`endif

    assign bus.choice   = choice_q;
    assign bus.ram_wen  = ram_wen_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.raddr1   = raddr1_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ram_reg_mover.sv
// Directed bench for ram_reg_mover; outputs are sampled on the falling clock edge.
// Define MOVER_STAT_EN to also check the xfer_cnt statistic.
module tb_ram_reg_mover;
    localparam int RD_LAT = 1;

    // ctl = {choice, ram_wen, we, busy, done}
    localparam logic [5:0] CTL_IDLE = 6'b11_0_0_0_0;
    localparam logic [5:0] CTL_TX   = 6'b00_1_0_1_0;
    localparam logic [5:0] CTL_DONE = 6'b11_0_0_1_1;

    localparam logic [15:0] WRAP_A [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    localparam logic [4:0]  WRAP_R [4] = '{5'd30, 5'd31, 5'd0, 5'd1};

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    ram_reg_mover_if bus ();

    ram_reg_mover #(.RD_LAT(RD_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    wire [5:0] ctl = {bus.choice, bus.ram_wen, bus.we, bus.busy, bus.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start(input logic d, input logic [15:0] rb, input logic [4:0] gb,
                               input logic [5:0] n);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dir      = d;
        bus.ram_base = rb;
        bus.reg_base = gb;
        bus.count    = n;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({ctl, bus.ram_addr, bus.waddr, bus.raddr1} !== {CTL_IDLE, 16'h0, 5'd0, 5'd0}) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", {ctl, bus.ram_addr, bus.waddr, bus.raddr1},
                     {CTL_IDLE, 16'h0, 5'd0, 5'd0});
        end
`ifdef MOVER_STAT_EN
        total++;
        if (bus.xfer_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_xfer_cnt got=%h exp=0000", bus.xfer_cnt);
        end
`endif
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reg_to_ram();
        logic [5:0] exp;
        pulse_start(1'b1, 16'h0001, 5'd1, 6'd4);
        for (int c = 1; c <= 6; c++) begin
            exp = (c <= 4) ? CTL_TX : (c == 5) ? CTL_DONE : CTL_IDLE;
            total++;
            if (ctl !== exp) begin
                bad++;
                $display("FAIL tx_ctl cycle %0d got=%b exp=%b", c, ctl, exp);
            end
            if (c <= 4) begin
                total++;
                if (bus.ram_addr !== 16'(c) || bus.raddr1 !== 5'(c)) begin
                    bad++;
                    $display("FAIL tx_addr cycle %0d got=%h/%0d exp=%h/%0d", c, bus.ram_addr,
                             bus.raddr1, 16'(c), c);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ram_to_reg();
        logic [5:0] exp;
        logic       e_we;
        int         n = 32;
        pulse_start(1'b0, 16'h0010, 5'd0, 6'd32);
        for (int c = 1; c <= n + RD_LAT + 2; c++) begin
            e_we = (c >= 1 + RD_LAT) && (c <= n + RD_LAT);
            exp  = {(c <= n + RD_LAT) ? 2'b01 : 2'b11, 1'b0, e_we,
                    1'(c <= n + RD_LAT + 1), 1'(c == n + RD_LAT + 1)};
            total++;
            if (ctl !== exp) begin
                bad++;
                $display("FAIL rx_ctl cycle %0d got=%b exp=%b", c, ctl, exp);
            end
            if (c <= n) begin
                total++;
                if (bus.ram_addr !== 16'(16'h0010 + c - 1)) begin
                    bad++;
                    $display("FAIL rx_ram_addr cycle %0d got=%h exp=%h", c, bus.ram_addr,
                             16'(16'h0010 + c - 1));
                end
            end
            if (e_we) begin
                total++;
                if (bus.waddr !== 5'(c - 1 - RD_LAT)) begin
                    bad++;
                    $display("FAIL rx_waddr cycle %0d got=%0d exp=%0d", c, bus.waddr, c - 1 - RD_LAT);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stat();
`ifdef MOVER_STAT_EN
        total++;
        if (bus.xfer_cnt !== 16'd36) begin
            bad++;
            $display("FAIL stat_xfer_cnt got=%0d exp=36", bus.xfer_cnt);
        end
`endif
    endtask

    task automatic test_wrap();
        pulse_start(1'b1, 16'hFFFE, 5'd30, 6'd4);
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (c <= 4) begin
                if ({ctl, bus.ram_addr, bus.raddr1} !== {CTL_TX, WRAP_A[c-1], WRAP_R[c-1]}) begin
                    bad++;
                    $display("FAIL wrap cycle %0d got=%h exp=%h", c, {ctl, bus.ram_addr, bus.raddr1},
                             {CTL_TX, WRAP_A[c-1], WRAP_R[c-1]});
                end
            end else if (ctl !== CTL_DONE) begin
                bad++;
                $display("FAIL wrap_done got=%b exp=%b", ctl, CTL_DONE);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_count_zero();
        pulse_start(1'b0, 16'h0005, 5'd5, 6'd0);
        for (int c = 1; c <= 2; c++) begin
            total++;
            if (ctl !== ((c == 1) ? CTL_DONE : CTL_IDLE)) begin
                bad++;
                $display("FAIL count_zero cycle %0d got=%b exp=%b", c, ctl,
                         (c == 1) ? CTL_DONE : CTL_IDLE);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clamp();
        int         n_we    = 0;
        int         done_at = 0;
        logic [4:0] last_wa = '0;
        pulse_start(1'b0, 16'h0100, 5'd3, 6'd40);
        for (int c = 1; c <= 40; c++) begin
            if (bus.we === 1'b1) begin
                n_we++;
                last_wa = bus.waddr;
            end
            if (bus.done === 1'b1 && done_at == 0) done_at = c;
            @(negedge clk);
        end
        total++;
        if (n_we != 32) begin
            bad++;
            $display("FAIL clamp_writes got=%0d exp=32", n_we);
        end
        total++;
        if (done_at != 32 + RD_LAT + 1 || last_wa !== 5'd2) begin
            bad++;
            $display("FAIL clamp_done_waddr got=%0d/%0d exp=%0d/2", done_at, last_wa, 32 + RD_LAT + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        pulse_start(1'b1, 16'h0200, 5'd0, 6'd8);
        for (int c = 1; c <= 11; c++) begin
            exp = (c <= 8) ? CTL_TX : (c == 9) ? CTL_DONE : CTL_IDLE;
            total++;
            if (ctl !== exp) begin
                bad++;
                $display("FAIL busy_start_ctl cycle %0d got=%b exp=%b", c, ctl, exp);
            end
            if (c <= 8) begin
                total++;
                if (bus.ram_addr !== 16'(16'h0200 + c - 1)) begin
                    bad++;
                    $display("FAIL busy_start_addr cycle %0d got=%h exp=%h", c, bus.ram_addr,
                             16'(16'h0200 + c - 1));
                end
            end
            // A start mid-transfer and one coinciding with done must both be dropped.
            bus.start    = (c == 2) || (c == 9);
            bus.dir      = 1'b0;
            bus.ram_base = 16'h0900;
            bus.count    = 6'd3;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_abort();
        pulse_start(1'b1, 16'h0300, 5'd0, 6'd6);
        for (int c = 1; c <= 3; c++) begin
            total++;
            if ({ctl, bus.ram_addr} !== {CTL_TX, 16'(16'h0300 + c - 1)}) begin
                bad++;
                $display("FAIL abort_pre cycle %0d got=%h exp=%h", c, {ctl, bus.ram_addr},
                         {CTL_TX, 16'(16'h0300 + c - 1)});
            end
            if (c < 3) @(negedge clk);
        end
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        total++;
        if ({ctl, bus.ram_addr, bus.waddr, bus.raddr1} !== {CTL_IDLE, 16'h0, 5'd0, 5'd0}) begin
            bad++;
            $display("FAIL abort_reset got=%h exp=%h", {ctl, bus.ram_addr, bus.waddr, bus.raddr1},
                     {CTL_IDLE, 16'h0, 5'd0, 5'd0});
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) resetn = 1'b1;
            total++;
            if (ctl !== CTL_IDLE) begin
                bad++;
                $display("FAIL abort_idle step %0d got=%b exp=%b", c, ctl, CTL_IDLE);
            end
        end
        pulse_start(1'b1, 16'h0007, 5'd7, 6'd1);
        total++;
        if ({ctl, bus.ram_addr, bus.raddr1} !== {CTL_TX, 16'h0007, 5'd7}) begin
            bad++;
            $display("FAIL abort_recover got=%h exp=%h", {ctl, bus.ram_addr, bus.raddr1},
                     {CTL_TX, 16'h0007, 5'd7});
        end
        @(negedge clk);
        total++;
        if (ctl !== CTL_DONE) begin
            bad++;
            $display("FAIL abort_recover_done got=%b exp=%b", ctl, CTL_DONE);
        end
        @(negedge clk);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        resetn       = 1'b0;
        bus.start    = 1'b0;
        bus.dir      = 1'b0;
        bus.ram_base = '0;
        bus.reg_base = '0;
        bus.count    = '0;
        test_reset();
        test_reg_to_ram();
        test_ram_to_reg();
        test_stat();
        test_wrap();
        test_count_zero();
        test_clamp();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_reg_mover.md
# ram_reg_mover

Sequencer that sits directly upstream of the RAM/register-file transfer block and drives its control ports (`choice`, `ram_wen`, `ram_addr`, `we`, `waddr`, `raddr1`). On a single `start` pulse, it moves a block of 1–32 words either from RAM into the register file or from the register file into RAM. It replaces hand-stepped address loops with a cycle-exact FSM, and it absorbs the RAM read latency on the RAM→reg path.

## Interface
- `RD_LAT`, 1: RAM read latency in cycles from `ram_addr` to valid `ram_rdata`. Legal values are 0, 1 and 2.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Accepted only in IDLE.
- `dir` input 1: transfer direction. 0 = RAM→reg; 1 = reg→RAM. Sampled with `start`.
- `ram_base` input 16: first RAM address. Sampled with `start`.
- `reg_base` input 5: first register index. Sampled with `start`.
- `count` input 6: number of words, 0..32. Values above 32 are clamped to 32. Sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` output 1: one-cycle completion pulse.
- `choice` output 2: data-path select. 11 = external/idle; 01 = `ram_rdata`→reg `wdata`; 00 = `rdata1`→`ram_wdata`.
- `ram_wen` output 1: RAM write enable.
- `ram_addr` output 16: RAM address.
- `we` output 1: register-file write enable.
- `waddr` output 5: register write index.
- `raddr1` output 5: register read index (read is combinational).
- `xfer_cnt` output 16: completed-word counter. Present only with `MOVER_STAT_EN`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - Outputs: `choice`=11, `ram_wen`=0, `we`=0.
  - `start`=1 latches `dir`, the base addresses and the clamped `count`.
  - If `count`=0, go to DONE with no writes. Otherwise go to RUN.
- **RUN, dir=1 (reg→RAM)**
  - Issue index k = 0..count-1, one per cycle.
  - Each cycle drives `choice`=00, `raddr1`=`reg_base`+k, `ram_addr`=`ram_base`+k, `ram_wen`=1.
  - After the last issue, go to DONE. DRAIN is skipped.
- **RUN, dir=0 (RAM→reg)**
  - Issue k drives `choice`=01 and `ram_addr`=`ram_base`+k.
  - The write for k appears RD_LAT cycles later, with `we`=1 and `waddr`=`reg_base`+k.
  - `waddr` is carried through an RD_LAT-deep valid/index shift pipeline.
- **DRAIN**
  - Lasts RD_LAT cycles. No new issues.
  - `choice` stays 01 while pipeline writes retire. Then go to DONE.
  - With RD_LAT=0, DRAIN is skipped.
- **DONE**
  - Lasts one cycle: `done`=1, `choice`=11, no enables. Then go to IDLE.
- Address arithmetic:
  - `ram_addr` wraps modulo 2^16 (0xFFFF+1 → 0x0000).
  - Register indices wrap modulo 32 (31+1 → 0).
  - The internal word counter is 6 bits wide.
- `start` while not in IDLE is ignored. It is neither queued nor re-sampled.
- `choice` never changes while a `we` or `ram_wen` is asserted for the same transfer.

## Timing
- Reset values, applied asynchronously:
  - `choice`=11.
  - `ram_wen`, `we`, `busy`, `done` = 0.
  - `ram_addr`, `waddr`, `raddr1` = 0.
  - `xfer_cnt`=0.
  - FSM in IDLE.
- All outputs are registered. The first issue appears the cycle after the `start` edge.
- Total cycles from `start` to `done`:
  - dir=1: `count`+1.
  - dir=0: `count`+RD_LAT+1.
  - count=0: 1.
- `busy` is high from the first issue cycle through the `done` cycle.
- `resetn` low mid-transfer aborts immediately:
  - No further writes; partial writes are not rolled back.
  - After release, the block sits in IDLE and waits for a new `start`.
- `start` in the same cycle as `done` is ignored. The earliest accepted `start` is the cycle after `done`.

## Configuration
- `MOVER_STAT_EN` defined:
  - `xfer_cnt` port exists.
  - It increments by 1 on every cycle with `we`=1 or `ram_wen`=1 driven by this block.
  - It saturates at 0xFFFF and is cleared only by reset.
- `MOVER_STAT_EN` undefined: the port and its counter logic are absent, and all other behaviour is identical.

## Test plan
- **reg→RAM:** dir=1, `ram_base`=0x0001, `reg_base`=1, `count`=4.
  - `ram_wen`=1 for 4 cycles with `ram_addr` 1..4, `raddr1` 1..4, `choice`=00.
  - `done` 5 cycles after `start`.
- **RAM→reg, RD_LAT=1:** dir=0, `ram_base`=0x0010, `reg_base`=0, `count`=32.
  - `ram_addr` 0x10..0x2F.
  - `we` runs one cycle behind with `waddr` 0..31.
  - `choice`=01 for 33 cycles. `done` at cycle 34.
- **Wrap:** dir=1, `ram_base`=0xFFFE, `reg_base`=30, `count`=4.
  - `ram_addr` sequence FFFE, FFFF, 0000, 0001.
  - `raddr1` sequence 30, 31, 0, 1.
- **count=0 and clamp:**
  - `count`=0 gives `done` 1 cycle after `start`, with no enables.
  - `count`=40 performs exactly 32 writes.
- **Start while busy, then abort:**
  - A second `start` mid-transfer produces no change.
  - `resetn`=0 after the 3rd write forces all outputs to reset values within the same cycle and produces no `done`.
- **`MOVER_STAT_EN`:** after the first two scenarios, `xfer_cnt`=36.
